// File: rtl/card_dealer_if.sv
// Request/status bundle between the game controller and the card dealer.
interface card_dealer_if;
   logic [2:0]  num;
   logic        deal;
   logic        clr_valid;
   logic [4:0]  clr_idx_a;
   logic [4:0]  clr_idx_b;
   logic [39:0] status;
   logic        busy;
   logic        done;
   logic [3:0]  cards_left;

   modport master (
      output num, deal, clr_valid, clr_idx_a, clr_idx_b,
      input  status, busy, done, cards_left
   );

   modport slave (
      input  num, deal, clr_valid, clr_idx_a, clr_idx_b,
      output status, busy, done, cards_left
   );
endinterface

// File: rtl/card_dealer.sv
// Deals a 2x5 board of pseudo-random cards (1..9) from a free-running LFSR and
// clears scored slot pairs on request.
module card_dealer #(
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int unsigned DEAL_SLOTS = 10
) (
   input logic          clk,
   input logic          rst_n,
   card_dealer_if.slave bus
);

   localparam logic [3:0] LastSlot = 4'(DEAL_SLOTS - 1);

   typedef enum logic [1:0] {StIdle, StDeal, StDone} state_e;

   state_e      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [2:0]  num_q, num_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [39:0] status_q, status_d;

   logic [2:0]  num_eff;
   logic [2:0]  col;
   logic [3:0]  card;
   logic        lfsr_fb;
   logic        clr_ok_a, clr_ok_b;
   logic [3:0]  cnt;

   assign num_eff = (bus.num == 3'd0) ? 3'd1 : ((bus.num > 3'd5) ? 3'd5 : bus.num);
   assign col     = (ptr_q >= 4'd5) ? 3'(ptr_q - 4'd5) : ptr_q[2:0];
   assign card    = (lfsr_q[3:0] % 4'd9) + 4'd1;
   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   // A 5-bit offset tops out at 28, so only word alignment needs checking here.
   assign clr_ok_a = (bus.clr_idx_a[1:0] == 2'b00);
   assign clr_ok_b = (bus.clr_idx_b[1:0] == 2'b00);

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      num_d    = num_q;
      status_d = status_q;
      lfsr_d   = {lfsr_q[14:0], lfsr_fb};
      unique case (state_q)
         StIdle: begin
            if (bus.deal) begin
               num_d   = num_eff;
               ptr_d   = 4'd0;
               state_d = StDeal;
            end else if (bus.clr_valid) begin
               if (clr_ok_a) status_d[{bus.clr_idx_a[4:2], 2'b00} +: 4] = 4'd0;
               if (clr_ok_b) status_d[{bus.clr_idx_b[4:2], 2'b00} +: 4] = 4'd0;
            end
         end
         StDeal: begin
            status_d[{ptr_q, 2'b00} +: 4] = (col < num_q) ? card : 4'd0;
            if (ptr_q == LastSlot) begin
               state_d = StDone;
            end else begin
               ptr_d = ptr_q + 4'd1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         ptr_q    <= 4'd0;
         num_q    <= 3'd0;
         lfsr_q   <= LFSR_SEED;
         status_q <= 40'd0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         num_q    <= num_d;
         lfsr_q   <= lfsr_d;
         status_q <= status_d;
      end
   end

   always_comb begin
      cnt = 4'd0;
      for (int k = 0; k < int'(DEAL_SLOTS); k++) begin
         cnt = cnt + {3'b000, (status_q[4*k +: 4] != 4'd0)};
      end
   end

   assign bus.status     = status_q;
   assign bus.busy       = (state_q == StDeal);
   assign bus.done       = (state_q == StDone);
   assign bus.cards_left = cnt;

endmodule

// File: tb/tb_card_dealer.sv
// Directed self-checking bench for card_dealer: reset, deals with several column
// counts, clear rules, ignored requests and reset mid-deal.
module tb_card_dealer;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   logic [15:0] m_lfsr;
   logic [39:0] exp_status;

   card_dealer_if bus ();

   card_dealer #(
      .LFSR_SEED (16'hACE1),
      .DEAL_SLOTS(10)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting left.
   always @(posedge clk) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] card_of(input logic [15:0] l);
      int v;
      v = int'(l[3:0]);
      return 4'(v % 9 + 1);
   endfunction

   function automatic int popc(input logic [39:0] s);
      int c;
      logic [3:0] nib;
      c = 0;
      for (int k = 0; k < 10; k++) begin
         nib = s[4*k +: 4];
         if (nib != 4'd0) c++;
      end
      return c;
   endfunction

   // inject: clear at T+5 and deal at T+7, both must be ignored.
   task automatic run_deal(input logic [2:0] n, input int ne, input bit with_clr, input bit inject);
      logic [39:0] e;
      e = '0;
      @(negedge clk);
      bus.num  = n;
      bus.deal = 1'b1;
      if (with_clr) begin
         bus.clr_valid = 1'b1;
         bus.clr_idx_a = 5'd0;
         bus.clr_idx_b = 5'd4;
      end
      @(negedge clk);
      bus.deal      = 1'b0;
      bus.clr_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         check("busy_in_deal", 64'(bus.busy), 64'd1);
         check("done_in_deal", 64'(bus.done), 64'd0);
         if ((k % 5) < ne) e[4*k +: 4] = card_of(m_lfsr);
         if (inject) begin
            if (k == 4) begin
               bus.clr_valid = 1'b1;
               bus.clr_idx_a = 5'd0;
               bus.clr_idx_b = 5'd4;
            end
            if (k == 5) bus.clr_valid = 1'b0;
            if (k == 6) bus.deal = 1'b1;
            if (k == 7) bus.deal = 1'b0;
         end
         @(negedge clk);
      end
      check("done_pulse", 64'(bus.done), 64'd1);
      check("busy_at_done", 64'(bus.busy), 64'd0);
      check("status_dealt", 64'(bus.status), 64'(e));
      check("cards_left_dealt", 64'(bus.cards_left), 64'(popc(e)));
      check("cards_left_expected", 64'(bus.cards_left), 64'(2 * ne));
      @(negedge clk);
      check("done_once", 64'(bus.done), 64'd0);
      check("busy_after", 64'(bus.busy), 64'd0);
      check("status_hold", 64'(bus.status), 64'(e));
      exp_status = e;
   endtask

   task automatic run_clear(input logic [4:0] a, input logic [4:0] b, input logic [9:0] slots,
                            input int left);
      @(negedge clk);
      bus.clr_valid = 1'b1;
      bus.clr_idx_a = a;
      bus.clr_idx_b = b;
      @(negedge clk);
      bus.clr_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (slots[k]) exp_status[4*k +: 4] = 4'd0;
      end
      check("status_clear", 64'(bus.status), 64'(exp_status));
      check("cards_left_clear", 64'(bus.cards_left), 64'(left));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      exp_status    = '0;
      rst_n         = 1'b0;
      bus.num       = 3'd5;
      bus.deal      = 1'b0;
      bus.clr_valid = 1'b0;
      bus.clr_idx_a = 5'd0;
      bus.clr_idx_b = 5'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         check("reset_idle", {18'd0, bus.status, bus.busy, bus.done, bus.cards_left}, 64'd0);
         @(negedge clk);
      end

      // Full board, then column clamping
      run_deal(3'd5, 5, 1'b0, 1'b0);
      run_deal(3'd3, 3, 1'b0, 1'b0);
      check("num3_empty_slots", 64'(exp_status & 40'hFF_000F_F000), 64'd0);
      run_deal(3'd0, 1, 1'b0, 1'b0);
      run_deal(3'd7, 5, 1'b0, 1'b0);

      // Clears: pair, duplicate already-empty, invalid offsets
      run_clear(5'd0,  5'd24, 10'b00_0100_0001, 8);
      run_clear(5'd24, 5'd24, 10'b00_0000_0000, 8);
      run_clear(5'd31, 5'd2,  10'b00_0000_0000, 8);

      // Deal beats a same-cycle clear; requests during the deal are dropped
      run_deal(3'd5, 5, 1'b1, 1'b1);

      // Reset in the middle of a deal
      @(negedge clk);
      bus.num  = 3'd5;
      bus.deal = 1'b1;
      @(negedge clk);
      bus.deal = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_status", 64'(bus.status), 64'd0);
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_cards_left", 64'(bus.cards_left), 64'd0);
      for (int i = 0; i < 12; i++) begin
         check("abort_no_done", 64'({bus.done, bus.busy}), 64'd0);
         @(negedge clk);
      end
      run_deal(3'd5, 5, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
